// File: rtl/bcd_counter_9999.sv
// bcd_counter_9999: 4-digit BCD up/down counter stepped by tick_in edges; COUNT_SATURATE_EN clamps at 0000/9999 instead of wrapping.
module bcd_counter_9999 #(
  parameter bit          EDGE_BOTH = 1'b0,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        en,
  input  logic        up_dn,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] bcd_out,
  output logic        tc,
  output logic        load_err
);
  logic        tick_q, tick_d;
  logic [15:0] cnt_q, cnt_d, cnt_up, cnt_dn;
  logic        tc_q, tc_d, err_q, err_d;
  logic        qual, ld_ok, at_lim, cy, bw;
  always_comb begin
    qual   = (EDGE_BOTH ? (tick_in ^ tick_q) : (tick_in & ~tick_q)) & en;
    tick_d = tick_in;
    ld_ok  = 1'b1;
    cy     = 1'b1;
    bw     = 1'b1;
    cnt_up = cnt_q;
    cnt_dn = cnt_q;
    for (int i = 0; i < 4; i++) begin
      ld_ok = ld_ok & (load_val[4*i+:4] <= 4'd9);
      cnt_up[4*i+:4] = cy ? (cnt_q[4*i+:4] == 4'd9 ? 4'd0 : cnt_q[4*i+:4] + 4'd1) : cnt_q[4*i+:4];
      cnt_dn[4*i+:4] = bw ? (cnt_q[4*i+:4] == 4'd0 ? 4'd9 : cnt_q[4*i+:4] - 4'd1) : cnt_q[4*i+:4];
      cy = cy & (cnt_q[4*i+:4] == 4'd9);
      bw = bw & (cnt_q[4*i+:4] == 4'd0);
    end
    // carry/borrow out of the top digit marks the 9999/0000 boundary
    at_lim = up_dn ? cy : bw;
`ifdef COUNT_SATURATE_EN
    cnt_d = load ? (ld_ok ? load_val : cnt_q) : (qual && !at_lim) ? (up_dn ? cnt_up : cnt_dn) : cnt_q;
`else
    cnt_d = load ? (ld_ok ? load_val : cnt_q) : qual ? (up_dn ? cnt_up : cnt_dn) : cnt_q;
`endif
    tc_d  = ~load & qual & at_lim;
    err_d = load & ~ld_ok;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= 1'b1;
      cnt_q  <= RESET_VAL;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      err_q  <= err_d;
    end
  end
  assign bcd_out  = cnt_q;
  assign tc       = tc_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_bcd_counter_9999.sv
// tb_bcd_counter_9999: directed and randomized checks of single-edge and both-edge counters against an integer model.
module tb_bcd_counter_9999;
`ifdef COUNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, tick_in = 1'b1, en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] bcd_a, bcd_b;
  logic        tc_a, tc_b, err_a, err_b;
  int          n_tests = 0, n_fail = 0;
  int          m_cnt[2];
  bit          m_td[2], m_tc[2], m_err[2];

  bcd_counter_9999 #(.EDGE_BOTH(1'b0), .RESET_VAL(16'h0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bcd_out(bcd_a), .tc(tc_a), .load_err(err_a));
  bcd_counter_9999 #(.EDGE_BOTH(1'b1), .RESET_VAL(16'h0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bcd_out(bcd_b), .tc(tc_b), .load_err(err_b));

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction
  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i+:4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // model index 0 = rising-edge counter, 1 = both-edge counter
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit e;
      if (!rst_n) begin
        m_cnt[k] = 0; m_td[k] = 1'b1; m_tc[k] = 1'b0; m_err[k] = 1'b0;
      end else begin
        e = (k == 1) ? (tick_in != m_td[k]) : (tick_in && !m_td[k]);
        m_td[k] = tick_in; m_tc[k] = 1'b0; m_err[k] = 1'b0;
        if (load) begin
          if (bcd_ok(load_val)) m_cnt[k] = from_bcd(load_val);
          else m_err[k] = 1'b1;
        end else if (e && en) begin
          if (up_dn) begin
            if (m_cnt[k] == 9999) begin m_tc[k] = 1'b1; m_cnt[k] = SAT ? 9999 : 0; end
            else m_cnt[k]++;
          end else begin
            if (m_cnt[k] == 0) begin m_tc[k] = 1'b1; m_cnt[k] = SAT ? 0 : 9999; end
            else m_cnt[k]--;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick_in = 1'b1; cyc();
    n_tests++;
    if ({bcd_a, tc_a, err_a} !== {16'h0000, 2'b00}) begin n_fail++; $display("FAIL reset: bcd/tc/err=%h expected %h", {bcd_a, tc_a, err_a}, {16'h0000, 2'b00}); end
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_tests++;
      if ({bcd_a, tc_a, bcd_b, tc_b} !== 34'h0) begin n_fail++; $display("FAIL reset_tick_high: a=%h b=%h expected 0000/0", {bcd_a, tc_a}, {bcd_b, tc_b}); end
    end
  endtask

  task automatic test_wrap_up();
    tick_in = 1'b0; load = 1'b1; load_val = 16'h9998; cyc();
    load = 1'b0;
    tick_in = 1'b1; cyc();
    n_tests++;
    if ({bcd_a, tc_a} !== {16'h9999, 1'b0}) begin n_fail++; $display("FAIL wrap_up_9999: %h expected %h", {bcd_a, tc_a}, {16'h9999, 1'b0}); end
    tick_in = 1'b0; cyc();
    tick_in = 1'b1; cyc();
    n_tests++;
    if ({bcd_a, tc_a} !== {(SAT ? 16'h9999 : 16'h0000), 1'b1}) begin n_fail++; $display("FAIL wrap_up_tc: %h expected %h", {bcd_a, tc_a}, {(SAT ? 16'h9999 : 16'h0000), 1'b1}); end
    tick_in = 1'b0; cyc();
    n_tests++;
    if (tc_a !== 1'b0) begin n_fail++; $display("FAIL wrap_up_tc_width: tc=%b expected 0", tc_a); end
  endtask

  task automatic test_wrap_down();
    up_dn = 1'b0; load = 1'b1; load_val = 16'h0000; cyc();
    load = 1'b0; tick_in = 1'b1; cyc();
    n_tests++;
    if ({bcd_a, tc_a} !== {(SAT ? 16'h0000 : 16'h9999), 1'b1}) begin n_fail++; $display("FAIL wrap_down: %h expected %h", {bcd_a, tc_a}, {(SAT ? 16'h0000 : 16'h9999), 1'b1}); end
    tick_in = 1'b0; cyc();
    load = 1'b1; load_val = 16'h1000; cyc();
    load = 1'b0; tick_in = 1'b1; cyc();
    n_tests++;
    if ({bcd_a, tc_a} !== {16'h0999, 1'b0}) begin n_fail++; $display("FAIL borrow_1000: %h expected %h", {bcd_a, tc_a}, {16'h0999, 1'b0}); end
    tick_in = 1'b0; cyc();
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 16'h12A4; cyc();
    n_tests++;
    if ({bcd_a, err_a} !== {16'h0999, 1'b1}) begin n_fail++; $display("FAIL load_reject: %h expected %h", {bcd_a, err_a}, {16'h0999, 1'b1}); end
    load = 1'b0; cyc();
    n_tests++;
    if ({bcd_a, err_a} !== {16'h0999, 1'b0}) begin n_fail++; $display("FAIL load_err_width: %h expected %h", {bcd_a, err_a}, {16'h0999, 1'b0}); end
    load = 1'b1; load_val = 16'h0042; tick_in = 1'b1; cyc();
    n_tests++;
    if ({bcd_a, tc_a, err_a} !== {16'h0042, 2'b00}) begin n_fail++; $display("FAIL load_over_tick: %h expected %h", {bcd_a, tc_a, err_a}, {16'h0042, 2'b00}); end
    load = 1'b0; cyc();
    n_tests++;
    if (bcd_a !== 16'h0042) begin n_fail++; $display("FAIL load_tick_dropped: %h expected 0042", bcd_a); end
    tick_in = 1'b0; cyc();
  endtask

  task automatic test_enable();
    load = 1'b1; load_val = 16'h0010; cyc();
    load = 1'b0; en = 1'b0; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin tick_in = 1'b1; cyc(); tick_in = 1'b0; cyc(); end
    en = 1'b1; cyc();
    n_tests++;
    if (bcd_a !== 16'h0010) begin n_fail++; $display("FAIL en_discard: %h expected 0010", bcd_a); end
    tick_in = 1'b1; cyc();
    n_tests++;
    if (bcd_a !== 16'h0011) begin n_fail++; $display("FAIL en_resume: %h expected 0011", bcd_a); end
    tick_in = 1'b0; cyc();
  endtask

  task automatic test_edge_both();
    load = 1'b1; load_val = 16'h0005; cyc();
    load = 1'b0; tick_in = 1'b1; cyc(); tick_in = 1'b0; cyc();
    n_tests++;
    if (bcd_b !== 16'h0007) begin n_fail++; $display("FAIL edge_both: %h expected 0007", bcd_b); end
    n_tests++;
    if (bcd_a !== 16'h0006) begin n_fail++; $display("FAIL edge_rise_only: %h expected 0006", bcd_a); end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_val = 16'h4321; cyc();
    load = 1'b0; tick_in = 1'b1; cyc(); tick_in = 1'b0;
    rst_n = 1'b0; cyc();
    n_tests++;
    if ({bcd_a, bcd_b} !== 32'h0) begin n_fail++; $display("FAIL reset_mid: a=%h b=%h expected 0000", bcd_a, bcd_b); end
    rst_n = 1'b1; cyc();
    tick_in = 1'b1; cyc();
    n_tests++;
    if (bcd_a !== 16'h0001) begin n_fail++; $display("FAIL reset_resume: %h expected 0001", bcd_a); end
    tick_in = 1'b0; cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      en      = ($urandom_range(0, 3) != 0);
      up_dn   = ($urandom_range(0, 2) != 0) ? up_dn : ~up_dn;
      tick_in = ($urandom_range(0, 2) == 0) ? ~tick_in : tick_in;
      load    = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: load_val = 16'h9999;
        1: load_val = 16'h0000;
        2: load_val = 16'($urandom);
        default: load_val = to_bcd($urandom_range(0, 9999));
      endcase
      cyc();
      n_tests++;
      if ({bcd_a, tc_a, err_a} !== {to_bcd(m_cnt[0]), m_tc[0], m_err[0]}) begin
        n_fail++; $display("FAIL rand_rise cyc %0d: bcd/tc/err=%h expected %h", i, {bcd_a, tc_a, err_a}, {to_bcd(m_cnt[0]), m_tc[0], m_err[0]});
      end
      n_tests++;
      if ({bcd_b, tc_b, err_b} !== {to_bcd(m_cnt[1]), m_tc[1], m_err[1]}) begin
        n_fail++; $display("FAIL rand_both cyc %0d: bcd/tc/err=%h expected %h", i, {bcd_b, tc_b, err_b}, {to_bcd(m_cnt[1]), m_tc[1], m_err[1]});
      end
      n_tests++;
      if ((tc_a & err_a) !== 1'b0) begin n_fail++; $display("FAIL rand_tc_err_excl cyc %0d: tc&err=%b expected 0", i, tc_a & err_a); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load();
    test_enable();
    test_edge_both();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
